// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection,
// branch/jump flush, downstream hold and a saturating load-use bubble counter.
module id_ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic                  id_ALUSrc,
  input  logic                  id_MemtoReg,
  input  logic                  id_RegWrite,
  input  logic                  id_MemRead,
  input  logic                  id_MemWrite,
  input  logic                  id_Branch,
  input  logic                  id_Jump,
  input  logic                  id_JumpReg,
  input  logic [1:0]            id_ALUOp,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic [DATA_W-1:0]     id_rd1,
  input  logic [DATA_W-1:0]     id_rd2,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [2:0]            id_funct3,
  input  logic [6:0]            id_funct7,
  input  logic                  flush,
  input  logic                  hold,
  output logic                  ex_valid,
  output logic                  ex_ALUSrc,
  output logic                  ex_MemtoReg,
  output logic                  ex_RegWrite,
  output logic                  ex_MemRead,
  output logic                  ex_MemWrite,
  output logic                  ex_Branch,
  output logic                  ex_Jump,
  output logic                  ex_JumpReg,
  output logic [1:0]            ex_ALUOp,
  output logic [DATA_W-1:0]     ex_pc,
  output logic [DATA_W-1:0]     ex_rd1,
  output logic [DATA_W-1:0]     ex_rd2,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [2:0]            ex_funct3,
  output logic [6:0]            ex_funct7,
  output logic                  load_use_stall,
  output logic [CNT_W-1:0]      bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Control bits packed as {ALUSrc, MemtoReg, RegWrite, MemRead,
  // MemWrite, Branch, Jump, JumpReg}.
  logic [7:0]            id_ctrl;
  logic                  valid_p1;
  logic [7:0]            ctrl_p1;
  logic [1:0]            aluop_p1;
  logic [DATA_W-1:0]     pc_p1, rd1_p1, rd2_p1, imm_p1;
  logic [REG_ADDR_W-1:0] rs1_p1, rs2_p1, rd_p1;
  logic [2:0]            funct3_p1;
  logic [6:0]            funct7_p1;
  logic [CNT_W-1:0]      cnt_p1;

  assign id_ctrl = {id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead,
                    id_MemWrite, id_Branch, id_Jump, id_JumpReg};

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  // A flush kills the ID instruction, so no stall is needed then.
  assign load_use_stall = id_valid & valid_p1 & ctrl_p1[4] &
                          (rd_p1 != '0) &
                          ((rd_p1 == id_rs1) | (rd_p1 == id_rs2)) & ~flush;

  // ---- ID -> EX register boundary (p1) ----
  // Priority: reset, hold, flush bubble, load-use bubble, normal capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_p1  <= 1'b0;
      ctrl_p1   <= '0;
      aluop_p1  <= '0;
      pc_p1     <= '0;
      rd1_p1    <= '0;
      rd2_p1    <= '0;
      imm_p1    <= '0;
      rs1_p1    <= '0;
      rs2_p1    <= '0;
      rd_p1     <= '0;
      funct3_p1 <= '0;
      funct7_p1 <= '0;
      cnt_p1    <= '0;
    end else if (!hold) begin
      if (flush || load_use_stall) begin
        valid_p1  <= 1'b0;
        ctrl_p1   <= '0;
        aluop_p1  <= '0;
        pc_p1     <= '0;
        rd1_p1    <= '0;
        rd2_p1    <= '0;
        imm_p1    <= '0;
        rs1_p1    <= '0;
        rs2_p1    <= '0;
        rd_p1     <= '0;
        funct3_p1 <= '0;
        funct7_p1 <= '0;
        if (load_use_stall) cnt_p1 <= sat_inc(cnt_p1);
      end else begin
        // An empty slot carries data but never any control side effects.
        valid_p1  <= id_valid;
        ctrl_p1   <= id_valid ? id_ctrl : 8'd0;
        aluop_p1  <= id_valid ? id_ALUOp : 2'd0;
        pc_p1     <= id_pc;
        rd1_p1    <= id_rd1;
        rd2_p1    <= id_rd2;
        imm_p1    <= id_imm;
        rs1_p1    <= id_rs1;
        rs2_p1    <= id_rs2;
        rd_p1     <= id_rd;
        funct3_p1 <= id_funct3;
        funct7_p1 <= id_funct7;
      end
    end
  end

  assign ex_valid = valid_p1;
  assign {ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead,
          ex_MemWrite, ex_Branch, ex_Jump, ex_JumpReg} = ctrl_p1;
  assign ex_ALUOp   = aluop_p1;
  assign ex_pc      = pc_p1;
  assign ex_rd1     = rd1_p1;
  assign ex_rd2     = rd2_p1;
  assign ex_imm     = imm_p1;
  assign ex_rs1     = rs1_p1;
  assign ex_rs2     = rs2_p1;
  assign ex_rd      = rd_p1;
  assign ex_funct3  = funct3_p1;
  assign ex_funct7  = funct7_p1;
  assign bubble_cnt = cnt_p1;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register directly downstream of the instruction decoder/Controller.
- Latches the decoded control bits and operand fields into the EX stage each cycle.
- Detects load-use hazards against the instruction currently in EX and inserts a bubble when one is found.
- Honours a branch/jump flush from EX and a global hold from later stages, and keeps a saturating count of load-use bubbles for performance monitoring.

Parameters:
DATA_W, 32, width of PC, register operands and immediate
REG_ADDR_W, 5, width of register specifiers
CNT_W, 16, width of load-use bubble counter

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset
id_valid  input  1  ID holds a real instruction
id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch, id_Jump, id_JumpReg  input  1 each  decoded control bits
id_ALUOp  input  2  decoded ALU class (00 ld/st, 01 branch, 10 R/I, 11 LUI)
id_pc  input  DATA_W  PC of ID instruction
id_rd1, id_rd2  input  DATA_W  register file read data
id_imm  input  DATA_W  sign-extended immediate
id_rs1, id_rs2, id_rd  input  REG_ADDR_W  register specifiers
id_funct3  input  3  instruction funct3
id_funct7  input  7  instruction funct7
flush  input  1  EX resolved taken branch/jump; kill ID instruction
hold  input  1  downstream stall; freeze this register
ex_valid  output  1  EX holds a real instruction
ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump, ex_JumpReg  output  1 each  registered control
ex_ALUOp  output  2  registered ALU class
ex_pc, ex_rd1, ex_rd2, ex_imm  output  DATA_W  registered data
ex_rs1, ex_rs2, ex_rd  output  REG_ADDR_W  registered specifiers
ex_funct3  output  3  registered funct3
ex_funct7  output  7  registered funct7
load_use_stall  output  1  combinational; freeze PC and IF/ID this cycle
bubble_cnt  output  CNT_W  count of load-use bubbles inserted

Behaviour:
- Registered outputs have a latency of 1 cycle, ID to EX.
- load_use_stall (combinational) = id_valid & ex_valid & ex_MemRead & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)) & ~flush. It is 0 whenever flush is 1.
- Bubble: ex_valid=0, every control output 0, ALUOp=00, and all data and specifier outputs 0.
- Per rising edge, in priority order:
  1. reset==0: all registered outputs 0, bubble_cnt=0.
  2. hold==1: every register keeps its value, including bubble_cnt. load_use_stall is still driven but has no local effect.
  3. flush==1: load bubble. bubble_cnt is unchanged.
  4. load_use_stall==1: load bubble; bubble_cnt += 1, saturating at 2^CNT_W-1.
  5. Otherwise, capture all id_* fields and set ex_valid=id_valid. If id_valid==0, force every control output to 0 (data still captured).
- The stalled ID instruction stays in place because upstream freezes on load_use_stall. On the next edge the comparison is against the bubble (ex_valid=0), so it passes: exactly one bubble per load-use pair.
- x0 destination (ex_rd==0) never causes a stall.
- Reset asserted mid-stall or mid-hold clears everything on that edge. No stall persists after reset.
- The counter wraps never; it holds at the all-ones value.

Test Plan:
- Reset: drive reset=0 for 2 cycles with random id_* -> all ex_* =0, ex_valid=0, bubble_cnt=0, load_use_stall=0.
- Pass-through: id_valid=1, R-type (RegWrite=1, ALUOp=10), id_pc=0x40, rd1=5, rd2=7, rd=3 -> next cycle ex_* match exactly; load_use_stall=0.
- Load-use: EX=lw x5 (MemRead=1, rd=5), ID=add rs1=5 -> load_use_stall=1. Next edge: ex_valid=0, all control 0, bubble_cnt=1. Following edge: add enters EX with ex_rs1=5, stall=0.
- x0 and flush: EX lw rd=0, ID rs1=0 -> no stall. EX lw rd=5, ID rs2=5 with flush=1 -> stall=0, bubble loaded, bubble_cnt unchanged.
- Hold: hold=1 for 3 cycles while id_* changes and a load-use condition is present -> ex_* and bubble_cnt frozen. Release -> normal priority resumes.
- Saturation: CNT_W=2, force 5 consecutive load-use bubbles -> bubble_cnt reads 1,2,3,3,3.
